iobus_initiator: RTL and testbench

- Single-transaction initiator for the MCS-style IO bus: strobes, 32-bit address/data, byte enables, `io_ready` completion.
- Converts a valid/ready command stream into one IO bus access and returns read data or a timeout flag on a valid/ready response stream.
- Lets a non-CPU agent (SPI/UART command bridge, test sequencer) drive the peripheral responders on the same bus (behind an arbiter).

---
 rtl/iobus_initiator.sv | 77 +++++++
 tb/tb_iobus_initiator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/iobus_initiator.sv
// iobus_initiator: converts one valid/ready command into a single IO bus access and returns data or timeout
module iobus_initiator #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_BITS = 8
) (
  input  logic        io_clk,
  input  logic        io_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_be,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        io_addr_strobe,
  output logic        io_read_strobe,
  output logic        io_write_strobe,
  output logic [31:0] io_address,
  output logic [3:0]  io_byte_enable,
  output logic [31:0] io_write_data,
  input  logic [31:0] io_read_data,
  input  logic        io_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [TO_BITS-1:0] cnt, cnt_nx;
  logic wr, expire, done;
  // cmd_ready is also forced low while reset is held so every output reads 0 in reset
  assign cmd_ready = state == IDLE && !io_rst;
  assign rsp_valid = state == RESP;
  assign busy = state == ISSUE || state == WAIT;
  assign io_addr_strobe = state == ISSUE;
  assign io_write_strobe = state == ISSUE && wr;
  assign io_read_strobe = state == ISSUE && !wr;
  // completion detect, next state and wait counter; the strobe cycle counts as wait 0
  always_comb begin
    expire = TIMEOUT_CYCLES != 0 && state == WAIT && cnt == TO_BITS'(TIMEOUT_CYCLES);
    done = busy && (io_ready || expire);
    state_nx = state == IDLE ? (cmd_valid ? ISSUE : IDLE) :
               state == RESP ? (rsp_ready ? IDLE : RESP) :
               done ? RESP : WAIT;
    cnt_nx = state == ISSUE ? TO_BITS'(1) : state == WAIT ? cnt + TO_BITS'(1) : cnt;
  end
  // state, bus-side command latch and response registers
  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      state <= IDLE;
      cnt <= '0;
      wr <= 1'b0;
      io_address <= '0;
      io_byte_enable <= '0;
      io_write_data <= '0;
      rsp_rdata <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (state == IDLE && cmd_valid) begin
        wr <= cmd_write;
        io_address <= cmd_addr;
        io_byte_enable <= cmd_be;
        io_write_data <= cmd_wdata;
      end
      if (done) begin
        rsp_rdata <= io_ready && !wr ? io_read_data : '0;
        rsp_timeout <= !io_ready;
      end else if (state == RESP && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_timeout <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_iobus_initiator.sv
// tb_iobus_initiator: directed checks of three initiators (timeouts 255, 4, 3) sharing the bus-side inputs
module tb_iobus_initiator;
  logic io_clk = 1'b0, io_rst = 1'b1;
  logic cmd_write = 1'b0, io_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, io_read_data = '0;
  logic [3:0] cmd_be = '0;
  logic cmd_valid [3], rsp_ready [3];
  logic cmd_ready [3], rsp_valid [3], rsp_timeout [3], as [3], rs [3], ws [3], busy [3];
  logic [31:0] rsp_rdata [3], io_address [3], io_write_data [3];
  logic [3:0] io_byte_enable [3];
  int checks = 0, errors = 0;
  int n;

  always #5 io_clk = ~io_clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    iobus_initiator #(.TIMEOUT_CYCLES(g == 0 ? 255 : 5 - g), .TO_BITS(8)) dut (
      .io_clk(io_clk), .io_rst(io_rst),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]),
      .rsp_timeout(rsp_timeout[g]),
      .io_addr_strobe(as[g]), .io_read_strobe(rs[g]), .io_write_strobe(ws[g]),
      .io_address(io_address[g]), .io_byte_enable(io_byte_enable[g]),
      .io_write_data(io_write_data[g]), .io_read_data(io_read_data),
      .io_ready(io_ready), .busy(busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge io_clk);
    #1;
  endtask

  task automatic issue(input int u, input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    cmd_write = w; cmd_addr = a; cmd_be = b; cmd_wdata = d;
    cmd_valid[u] = 1'b1;
    chk("accept_ready", 32'(cmd_ready[u]), 1);
    tick;
    cmd_valid[u] = 1'b0;
  endtask

  task automatic handshake(input int u);
    rsp_ready[u] = 1'b1;
    tick;
    rsp_ready[u] = 1'b0;
    chk("hs_valid", 32'(rsp_valid[u]), 0);
    chk("hs_cmd_ready", 32'(cmd_ready[u]), 1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin cmd_valid[i] = 1'b0; rsp_ready[i] = 1'b0; end
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready[0]), 0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 0);
    chk("rst_addr", io_address[0], 0);
    chk("rst_busy", 32'(busy[0]), 0);
    tick;
    io_rst = 1'b0;
    tick;
    chk("idle_cmd_ready", 32'(cmd_ready[0]), 1);

    // 1: read, ready in strobe cycle
    issue(0, 1'b0, 32'hC000_0010, 4'hF, 32'h0);
    chk("t1_as", 32'(as[0]), 1);
    chk("t1_rs", 32'(rs[0]), 1);
    chk("t1_ws", 32'(ws[0]), 0);
    chk("t1_addr", io_address[0], 32'hC000_0010);
    io_ready = 1'b1; io_read_data = 32'hDEAD_BEEF;
    tick;
    io_ready = 1'b0; io_read_data = 32'h0;
    chk("t1_valid", 32'(rsp_valid[0]), 1);
    chk("t1_as_off", 32'(as[0]), 0);
    chk("t1_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
    chk("t1_timeout", 32'(rsp_timeout[0]), 0);
    handshake(0);

    // 2: write, ready 5 cycles after strobe
    io_read_data = 32'hFFFF_FFFF;
    issue(0, 1'b1, 32'hC000_0020, 4'h3, 32'h1234_5678);
    chk("t2_ws", 32'(ws[0]), 1);
    chk("t2_rs", 32'(rs[0]), 0);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) begin
        tick;
        chk("t2_strobe_off", 32'(as[0] | ws[0]), 0);
      end
      chk("t2_addr", io_address[0], 32'hC000_0020);
      chk("t2_be", 32'(io_byte_enable[0]), 3);
      chk("t2_wdata", io_write_data[0], 32'h1234_5678);
      chk("t2_busy", 32'(busy[0]), 1);
      chk("t2_no_rsp", 32'(rsp_valid[0]), 0);
    end
    io_ready = 1'b1;
    tick;
    io_ready = 1'b0;
    chk("t2_valid", 32'(rsp_valid[0]), 1);
    chk("t2_rdata", rsp_rdata[0], 0);
    chk("t2_timeout", 32'(rsp_timeout[0]), 0);
    chk("t2_busy_off", 32'(busy[0]), 0);
    handshake(0);
    chk("t2_addr_kept", io_address[0], 32'hC000_0020);

    // 3: timeout after 4 wait cycles, stray ready afterwards ignored
    io_read_data = 32'h1111_2222;
    issue(1, 1'b0, 32'hC000_0030, 4'hF, 32'h0);
    chk("t3_as", 32'(as[1]), 1);
    n = 0;
    while (!rsp_valid[1] && n < 20) begin tick; n++; end
    chk("t3_latency", n, 5);
    chk("t3_timeout", 32'(rsp_timeout[1]), 1);
    chk("t3_rdata", rsp_rdata[1], 0);
    handshake(1);
    chk("t3_timeout_clr", 32'(rsp_timeout[1]), 0);
    io_ready = 1'b1;
    tick;
    io_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_stray", 32'(rsp_valid[1] | busy[1]), 0);
      tick;
    end

    // 4: response backpressure, then back-to-back command
    issue(0, 1'b0, 32'hC000_0040, 4'hF, 32'h0);
    io_ready = 1'b1; io_read_data = 32'h0000_0055;
    tick;
    io_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      io_read_data = 32'(k) + 32'h100;
      chk("t4_valid", 32'(rsp_valid[0]), 1);
      chk("t4_rdata", rsp_rdata[0], 32'h55);
      chk("t4_timeout", 32'(rsp_timeout[0]), 0);
      chk("t4_cmd_ready", 32'(cmd_ready[0]), 0);
      tick;
    end
    cmd_write = 1'b1; cmd_addr = 32'hC000_0044; cmd_be = 4'hC; cmd_wdata = 32'hCAFE_F00D;
    cmd_valid[0] = 1'b1;
    rsp_ready[0] = 1'b1;
    tick;
    rsp_ready[0] = 1'b0;
    chk("t4_hs_valid", 32'(rsp_valid[0]), 0);
    chk("t4_hs_cmd_ready", 32'(cmd_ready[0]), 1);
    chk("t4_hs_no_strobe", 32'(as[0]), 0);
    tick;
    cmd_valid[0] = 1'b0;
    chk("t4_b2b_ws", 32'(ws[0]), 1);
    chk("t4_b2b_addr", io_address[0], 32'hC000_0044);
    io_ready = 1'b1;
    tick;
    io_ready = 1'b0;
    chk("t4_b2b_valid", 32'(rsp_valid[0]), 1);
    handshake(0);

    // 5: asynchronous reset in WAIT
    issue(0, 1'b0, 32'hC000_0050, 4'hF, 32'h0);
    tick;
    tick;
    chk("t5_busy", 32'(busy[0]), 1);
    #2 io_rst = 1'b1;
    #1;
    chk("t5_busy_rst", 32'(busy[0]), 0);
    chk("t5_addr_rst", io_address[0], 0);
    chk("t5_valid_rst", 32'(rsp_valid[0]), 0);
    chk("t5_ready_rst", 32'(cmd_ready[0]), 0);
    chk("t5_as_rst", 32'(as[0] | rs[0] | ws[0]), 0);
    tick;
    #2 io_rst = 1'b0;
    tick;
    chk("t5_no_rsp", 32'(rsp_valid[0]), 0);
    issue(0, 1'b0, 32'hC000_0054, 4'hF, 32'h0);
    io_ready = 1'b1; io_read_data = 32'h1357_9BDF;
    tick;
    io_ready = 1'b0;
    chk("t5_valid", 32'(rsp_valid[0]), 1);
    chk("t5_rdata", rsp_rdata[0], 32'h1357_9BDF);
    handshake(0);

    // 6: ready in the same cycle as timeout
    issue(2, 1'b0, 32'hC000_0060, 4'hF, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick;
      chk("t6_wait", 32'(rsp_valid[2]), 0);
    end
    io_ready = 1'b1; io_read_data = 32'hA5A5_A5A5;
    tick;
    io_ready = 1'b0;
    chk("t6_valid", 32'(rsp_valid[2]), 1);
    chk("t6_timeout", 32'(rsp_timeout[2]), 0);
    chk("t6_rdata", rsp_rdata[2], 32'hA5A5_A5A5);
    handshake(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
